// File: rtl/perf_pkg.sv
// Shared types and event-channel assignments for the pipeline performance counter bank.
package perf_pkg;

  typedef enum logic [0:0] {
    StRun,
    StFrozen
  } perf_state_e;

  // Channel index of each standard pipeline statistic
  localparam int unsigned EV_BR_PRED_TAKEN      = 0;
  localparam int unsigned EV_BR_TAKEN           = 1;
  localparam int unsigned EV_BRANCH             = 2;
  localparam int unsigned EV_BTB_HIT            = 3;
  localparam int unsigned EV_BTB_HIT_PRED_TAKEN = 4;
  localparam int unsigned EV_PRED_TAKEN_CORRECT = 5;
  localparam int unsigned EV_STALL              = 6;
  localparam int unsigned EV_FLUSH              = 7;

  localparam int unsigned NUM_STD_EVENTS = 8;

endpackage

// File: rtl/perf_counter.sv
// One counter channel: live count, shadow copy and sticky overflow flag.
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 clear_i,
  input  logic                 snap_i,
  output logic [CNT_WIDTH-1:0] shadow_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    // Shadow always takes the value from before this cycle's clear or increment
    if (snap_i) begin
      shadow_d = cnt_q;
    end
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign shadow_o = shadow_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of pipeline event counters with shadow snapshot, halt/resume freeze and indexed reads.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter bit          SATURATE   = 1'b1,
  parameter int unsigned IDX_WIDTH  = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  count_en,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  clear,
  input  logic                  snapshot,
  input  logic                  halt,
  input  logic                  resume,
  input  logic                  rd_req,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_ovf,
  output logic                  rd_err,
  output logic                  frozen
);

  perf_state_e state_q, state_d;

  logic                  count_active;
  logic                  snap;
  logic [NUM_EVENTS-1:0] inc;
  logic [NUM_EVENTS-1:0] ovf;
  logic [CNT_WIDTH-1:0]  shadow [NUM_EVENTS];

  logic                 idx_err;
  logic [CNT_WIDTH-1:0] sel_shadow;
  logic                 sel_ovf;

  logic                 rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_ovf_q, rd_ovf_d;
  logic                 rd_err_q, rd_err_d;

  // A halting cycle already counts as frozen; its implicit snapshot holds the final counts
  assign count_active = (state_q == StRun) && !halt && count_en;
  assign snap         = snapshot || ((state_q == StRun) && halt);
  assign inc          = events & {NUM_EVENTS{count_active}};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (halt) state_d = StFrozen;
      StFrozen: if (resume && !halt) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_chan
    perf_counter #(
      .CNT_WIDTH(CNT_WIDTH),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc[i]),
      .clear_i (clear),
      .snap_i  (snap),
      .shadow_o(shadow[i]),
      .ovf_o   (ovf[i])
    );
  end

  assign idx_err = 32'(rd_idx) >= NUM_EVENTS;

  always_comb begin
    sel_shadow = '0;
    sel_ovf    = 1'b0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      if (32'(rd_idx) == i) begin
        sel_shadow = shadow[i];
        sel_ovf    = ovf[i];
      end
    end
  end

  always_comb begin
    rd_valid_d = rd_req;
    rd_err_d   = rd_req && idx_err;
    rd_data_d  = rd_req ? sel_shadow : '0;
    rd_ovf_d   = rd_req && sel_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_ovf_q   <= rd_ovf_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_ovf   = rd_ovf_q;
  assign rd_err   = rd_err_q;
  assign frozen   = (state_q == StFrozen);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: two banks (8ch saturating, 6ch wrapping, 4-bit counters) share stimulus.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       count_en;
  logic [7:0] events;
  logic       clear;
  logic       snapshot;
  logic       halt;
  logic       resume;
  logic       rd_req;
  logic [2:0] rd_idx;

  logic       rd_valid_a, rd_ovf_a, rd_err_a, frozen_a;
  logic [3:0] rd_data_a;
  logic       rd_valid_b, rd_ovf_b, rd_err_b, frozen_b;
  logic [3:0] rd_data_b;

  always #5 clk = ~clk;

  perf_counter_bank #(
    .NUM_EVENTS(8),
    .CNT_WIDTH (4),
    .SATURATE  (1'b1)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .count_en(count_en),
    .events  (events),
    .clear   (clear),
    .snapshot(snapshot),
    .halt    (halt),
    .resume  (resume),
    .rd_req  (rd_req),
    .rd_idx  (rd_idx),
    .rd_valid(rd_valid_a),
    .rd_data (rd_data_a),
    .rd_ovf  (rd_ovf_a),
    .rd_err  (rd_err_a),
    .frozen  (frozen_a)
  );

  perf_counter_bank #(
    .NUM_EVENTS(6),
    .CNT_WIDTH (4),
    .SATURATE  (1'b0)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .count_en(count_en),
    .events  (events[5:0]),
    .clear   (clear),
    .snapshot(snapshot),
    .halt    (halt),
    .resume  (resume),
    .rd_req  (rd_req),
    .rd_idx  (rd_idx),
    .rd_valid(rd_valid_b),
    .rd_data (rd_data_b),
    .rd_ovf  (rd_ovf_b),
    .rd_err  (rd_err_b),
    .frozen  (frozen_b)
  );

  typedef struct {
    logic [3:0]  data;
    logic        ovf;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  always @(negedge clk) begin
    if (rd_valid_a) begin
      if (q_a.size() == 0) begin
        chk("a_spurious_valid", 32'(rd_valid_a), 32'd0);
      end else begin
        ea = q_a.pop_front();
        chk("a_rd_data", 32'(rd_data_a), 32'(ea.data));
        chk("a_rd_ovf", 32'(rd_ovf_a), 32'(ea.ovf));
        chk("a_rd_err", 32'(rd_err_a), 32'(ea.err));
        chk("a_rd_latency", cyc, ea.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid_b) begin
      if (q_b.size() == 0) begin
        chk("b_spurious_valid", 32'(rd_valid_b), 32'd0);
      end else begin
        eb = q_b.pop_front();
        chk("b_rd_data", 32'(rd_data_b), 32'(eb.data));
        chk("b_rd_ovf", 32'(rd_ovf_b), 32'(eb.ovf));
        chk("b_rd_err", 32'(rd_err_b), 32'(eb.err));
        chk("b_rd_latency", cyc, eb.due);
      end
    end
  end

  task automatic step(input logic [7:0] ev, input logic cen, input logic clr, input logic snp,
                      input logic hlt, input logic res);
    @(negedge clk);
    events   = ev;
    count_en = cen;
    clear    = clr;
    snapshot = snp;
    halt     = hlt;
    resume   = res;
    rd_req   = 1'b0;
  endtask

  task automatic idle();
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Issue a read; bank b flags indices 6 and 7 as out of range with zero data
  task automatic read(input logic snp, input logic [2:0] idx, input logic [3:0] da,
                      input logic oa, input logic [3:0] db, input logic ob);
    exp_t e;
    @(negedge clk);
    events   = 8'h00;
    count_en = 1'b0;
    clear    = 1'b0;
    snapshot = snp;
    halt     = 1'b0;
    resume   = 1'b0;
    rd_req   = 1'b1;
    rd_idx   = idx;
    e.due  = cyc + 1;
    e.data = da;
    e.ovf  = oa;
    e.err  = 1'b0;
    q_a.push_back(e);
    e.err  = (idx >= 3'd6);
    e.data = e.err ? 4'd0 : db;
    e.ovf  = e.err ? 1'b0 : ob;
    q_b.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst      = 1'b1;
    events   = 8'h00;
    count_en = 1'b0;
    clear    = 1'b0;
    snapshot = 1'b0;
    halt     = 1'b0;
    resume   = 1'b0;
    rd_req   = 1'b0;
    rd_idx   = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_valid_a", 32'(rd_valid_a), 0);
    chk("rst_data_a", 32'(rd_data_a), 0);
    chk("rst_ovf_a", 32'(rd_ovf_a), 0);
    chk("rst_err_a", 32'(rd_err_a), 0);
    chk("rst_frozen_a", 32'(frozen_a), 0);
    chk("rst_valid_b", 32'(rd_valid_b), 0);
    chk("rst_frozen_b", 32'(frozen_b), 0);

    // Basic count: 5 events on channel 0
    repeat (5) step(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    read(1'b0, 3'd0, 4'd5, 1'b0, 4'd5, 1'b0);

    // Stall gating, then back-to-back reads of every index
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) read(1'b0, 3'(i), 4'd0, 1'b0, 4'd0, 1'b0);

    // 17 events on channel 2: saturate holds at 15, wrap lands on 1
    repeat (17) step(8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    read(1'b0, 3'd2, 4'd15, 1'b1, 4'd1, 1'b1);
    read(1'b0, 3'd1, 4'd0, 1'b0, 4'd0, 1'b0);

    // Simultaneous clear/snapshot/event, snapshot with event, read with snapshot
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) step(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    read(1'b0, 3'd1, 4'd7, 1'b0, 4'd7, 1'b0);
    step(8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    read(1'b1, 3'd1, 4'd0, 1'b0, 4'd0, 1'b0);
    read(1'b0, 3'd1, 4'd1, 1'b0, 4'd1, 1'b0);

    // Halt/resume
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("frozen_before_halt_edge", 32'(frozen_a), 0);
    repeat (5) step(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("frozen_a_after_halt", 32'(frozen_a), 1);
    chk("frozen_b_after_halt", 32'(frozen_b), 1);
    read(1'b0, 3'd0, 4'd3, 1'b0, 4'd3, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    chk("frozen_halt_beats_resume", 32'(frozen_a), 1);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("frozen_after_resume", 32'(frozen_a), 0);
    repeat (2) step(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    read(1'b0, 3'd0, 4'd5, 1'b0, 4'd5, 1'b0);

    // Mid-operation reset overrides halt, snapshot, events and a read request
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    events   = 8'hFF;
    count_en = 1'b1;
    snapshot = 1'b1;
    halt     = 1'b1;
    rd_req   = 1'b1;
    rd_idx   = 3'd0;
    @(negedge clk);
    rst      = 1'b0;
    events   = 8'h00;
    count_en = 1'b0;
    snapshot = 1'b0;
    halt     = 1'b0;
    rd_req   = 1'b0;
    chk("frozen_after_rst", 32'(frozen_a), 0);
    chk("valid_after_rst", 32'(rd_valid_a), 0);
    read(1'b1, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    read(1'b0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0);

    repeat (3) idle();
    chk("a_pending_reads", q_a.size(), 0);
    chk("b_pending_reads", q_b.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable, parametrised bank of event counters for the pipeline's microarchitectural statistics: branch predictions, BTB hits, mispredicts, stalls and similar. Every channel is gated by the pipeline advance qualifier, so a stalled stage never double-counts. Counters can be snapshotted into a shadow bank, frozen on halt, cleared, and read one channel at a time. The block sits beside `pipeline_datapath` inside `mp3` and replaces ad-hoc counters in the testbench.

## Interface
Parameters:
- `NUM_EVENTS`, default 8: number of counter channels; legal range 1–32.
- `CNT_WIDTH`, default 32: width of each counter, in bits.
- `SATURATE`, default 1: 1 means counters stick at all-ones; 0 means they wrap to 0.
- `IDX_WIDTH`, default `$clog2(NUM_EVENTS)`, minimum 1: width of the read index.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `count_en` in 1: pipeline advance qualifier (`loadReg`). Events count only when this is 1.
- `events` in NUM_EVENTS: per-channel increment requests, one bit each.
- `clear` in 1: zero all live counters and overflow flags.
- `snapshot` in 1: copy all live counters into the shadow bank.
- `halt` in 1: freeze counting. This is sticky until `rst` or `resume`.
- `resume` in 1: leave the FROZEN state.
- `rd_req` in 1: read request for the shadow bank.
- `rd_idx` in IDX_WIDTH: channel to read.
- `rd_valid` out 1: read data is valid.
- `rd_data` out CNT_WIDTH: shadow value of the selected channel.
- `rd_ovf` out 1: sticky overflow flag of the selected channel.
- `rd_err` out 1: asserted when `rd_idx >= NUM_EVENTS`.
- `frozen` out 1: the FSM is in the FROZEN state.

## Operation
FSM states:
- RUN (the reset state).
  - Each cycle with `count_en=1`, every channel `i` with `events[i]=1` increments by 1.
- FROZEN.
  - No increments occur.
  - `clear` and `snapshot` are still honoured.
- Transitions:
  - RUN→FROZEN on `halt=1`. Before entering FROZEN, the block performs an implicit snapshot that captures the final counts.
  - FROZEN→RUN on `resume=1` with `halt=0`.
  - If `halt` and `resume` are both 1, `halt` wins and the FSM stays in or enters FROZEN.

Arithmetic at all-ones:
- Saturate mode: the counter holds at all-ones and `ovf[i]` is set.
- Wrap mode: the counter becomes 0 and `ovf[i]` is set.
- `ovf[i]` clears only on `clear` or `rst`.

Simultaneous events in the same cycle:
- `clear` together with an event: the counter becomes 0 and the event is dropped.
- `snapshot` together with an event: the shadow captures the pre-increment value, and the live counter still increments.
- `clear` together with `snapshot`: the shadow captures the pre-clear values, then the live counters become 0.
- A read request in the same cycle as a snapshot returns the old shadow value.

Reads:
- Reads return shadow values only. Live counters are never read directly.
- An out-of-range index returns `rd_data=0`, `rd_ovf=0`, `rd_err=1`.

## Timing
Reset:
- All counters, shadows, `ovf`, `rd_valid`, `rd_data`, `rd_ovf`, `rd_err` and `frozen` are 0. The FSM is in RUN.
- An `rst` mid-operation overrides every other input in that cycle.

Latency:
- An event sampled at edge N is visible in the live counter after edge N.
- A snapshot is visible in the shadow after the same edge.
- `rd_req` at edge N produces `rd_valid=1` and data during cycle N+1. `rd_valid` lasts one cycle per request.
- Back-to-back requests give back-to-back responses, with no stall.

`frozen`:
- Rises the cycle after `halt` is sampled.
- Falls the cycle after `resume` is accepted.

## Structure
Package `perf_pkg` holds:
- The `perf_state_e` enum (RUN, FROZEN).
- Event index constants: `EV_BR_PRED_TAKEN`, `EV_BR_TAKEN`, `EV_BRANCH`, `EV_BTB_HIT`, `EV_BTB_HIT_PRED_TAKEN`, `EV_PRED_TAKEN_CORRECT`, `EV_STALL`, `EV_FLUSH`.

Sub-module `perf_counter`:
- One channel: live counter, shadow register and overflow flag.
- Parametrised by `CNT_WIDTH` and `SATURATE`.
- Instantiated `NUM_EVENTS` times in a generate loop.

## Test plan
- **Reset and basic count:** `rst`, then 5 cycles of `events[0]=1` with `count_en=1`, then `snapshot`, then read index 0. Expected: `rd_data=5`, `rd_ovf=0`, `rd_valid` on the cycle after the request.
- **Stall gating:** `events=8'hFF` with `count_en=0` for 10 cycles, then snapshot and read all channels. Expected: every value is 0.
- **Saturate vs wrap:** `CNT_WIDTH=4`, 17 events on channel 2.
  - `SATURATE=1`: `rd_data=15`, `rd_ovf=1`.
  - `SATURATE=0`: `rd_data=1`, `rd_ovf=1`.
- **Simultaneous events:** counter at 7; assert `clear`, `snapshot` and `events[1]` in one cycle. Expected: shadow 7, live 0. Then one more event, snapshot, read. Expected: 1.
- **Halt/resume:** 3 events, then `halt` in the same cycle as a 4th event, then 5 more events, then read. Expected: 3, with `frozen=1`. Then `resume`, 2 events, snapshot, read. Expected: 5.
- **Bad index:** `NUM_EVENTS=6`, `rd_idx=7`. Expected: `rd_err=1`, `rd_data=0`, `rd_valid=1`.
